hs_npu_result_collector: RTL and testbench
==========================================

HS_NPU_RESULT_COLLECTOR -- requirements
Module: hs_npu_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning output FIFO entries; legal values are powers of 2 and at least 16.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: lane 0 of a new result vector is present this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: collector can accept a new vector start this cycle.
REQ-006 SHALL have port results_in, input, signed [31:0] x 8: systolic array output lanes, lane j skewed j cycles later than lane 0.
REQ-007 SHALL have port cfg_relu_in, input, 1 bit: enable ReLU clamp.
REQ-008 SHALL have port cfg_shift_in, input, [4:0]: arithmetic right-shift amount for requantization.
REQ-009 SHALL have port data_out, output, signed [15:0] x 8: requantized aligned vector at FIFO head.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out holds a valid vector.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts data_out this cycle.
REQ-012 SHALL have port fifo_count_out, output, [$clog2(DEPTH):0]: current FIFO occupancy.
REQ-013 SHALL have port drop_err_out, output, 1 bit: sticky flag, set when a vector start is lost.

Function
REQ-014 SHALL give lane j a free-running delay line of (7-j) registers, shifting every cycle without gating; lane 7 has no delay.
REQ-015 SHALL, for a vector whose in_valid is high in cycle t, present all 8 aligned lanes combinationally in cycle t+7.
REQ-016 SHALL track vector validity in a 7-stage valid shift register, loaded with (in_valid && in_ready).
REQ-017 SHALL register the post-processed aligned vector at the end of cycle t+7 (post stage, valid in t+8).
REQ-018 SHALL write the FIFO at the end of cycle t+8, so out_valid rises no earlier than cycle t+9 (latency 9, no fall-through).
REQ-019 SHALL compute, per lane: if cfg_relu_in and x<0 then x=0.
REQ-020 SHALL then, if s=cfg_shift_in>0, compute (x + 2^(s-1)) >>> s in 33-bit signed arithmetic; if s=0, pass x unchanged.
REQ-021 SHALL then saturate the result to [-32768, 32767].
REQ-022 SHALL sample cfg_relu_in and cfg_shift_in in cycle t+7 of each vector; mid-stream changes affect only vectors aligning afterwards.
REQ-023 SHALL define inflight as the count of set bits in the valid pipe plus the post-stage valid bit (0..8).
REQ-024 SHALL drive in_ready = (fifo_count + inflight) < DEPTH, so an accepted vector never finds the FIFO full.
REQ-025 SHALL drop a vector when in_valid=1 and in_ready=0, and set drop_err_out, which holds until reset.
REQ-026 SHALL present the FIFO head on data_out whenever out_valid=1; it SHALL pop on out_valid && out_ready.
REQ-027 SHALL, on a simultaneous push and pop, leave fifo_count unchanged with correct ordering, including when full or when holding one entry.
REQ-028 SHALL wrap the read and write pointers modulo DEPTH.
REQ-029 SHALL drive data_out to 0 when the FIFO is empty.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, clear all lane delay registers, the valid pipe, the post stage, the FIFO pointers and count, and drop_err_out.
REQ-031 SHALL give these output values after reset: out_valid=0, data_out=0, fifo_count_out=0, drop_err_out=0, in_ready=1.
REQ-032 SHALL discard all in-flight vectors when reset is asserted mid-operation, with no FIFO write afterwards.

Verification
REQ-033 SHALL cover single vector: in_valid in cycle 0, lane j=1000+j delivered in cycle j, shift=2, relu=0, out_ready=1 -> out_valid first in cycle 9 with data_out[j]=(1000+j+2)>>>2 (lane 0 = 250).
REQ-034 SHALL cover arithmetic corners: inputs -5 (relu=1) -> 0; -6 (shift 2, relu=0) -> -1; 0x7FFFFFFF (shift 0) -> 32767; 0x80000000 (shift 0) -> -32768.
REQ-035 SHALL cover backpressure: out_ready=0 with in_valid every cycle -> exactly DEPTH vectors stored, in_ready falls once count+inflight=DEPTH, no data loss, in-order drain after out_ready=1.
REQ-036 SHALL cover a drop: in_valid=1 while in_ready=0 -> drop_err_out=1 from the next cycle onward, and the FIFO holds no extra entry.
REQ-037 SHALL cover full with simultaneous pop and push: count stays at DEPTH and the output sequence is unchanged.
REQ-038 SHALL cover reset mid-stream: rst_n=0 for one cycle with 3 vectors in flight and 2 in the FIFO -> next cycle out_valid=0 and count=0, and no stale vector emerges over the following 10 cycles.

Source files
------------

// File: rtl/hs_npu_result_collector.sv
// ---------------------------------------------------------------------------
// hs_npu_result_collector
//
// Collects the skewed output lanes of an 8-wide systolic array, de-skews them
// into aligned vectors, applies an optional ReLU and a rounding arithmetic
// right shift with 16-bit saturation, and queues the results in an output
// FIFO. The vector start handshake only accepts a new vector when the FIFO is
// guaranteed to have room for it and for every vector already in the pipe.
//
// Ports
//   clk            : sole clock, rising edge
//   rst_n          : synchronous active-low reset
//   in_valid       : lane 0 of a new result vector is present this cycle
//   in_ready       : a new vector start can be accepted this cycle
//   results_in[8]  : signed 32-bit lanes, lane j arrives j cycles after lane 0
//   cfg_relu_in    : clamp negative values to zero
//   cfg_shift_in   : rounding arithmetic right-shift amount
//   data_out[8]    : requantized vector at the FIFO head (0 when empty)
//   out_valid      : data_out holds a valid vector
//   out_ready      : consumer takes data_out this cycle
//   fifo_count_out : current FIFO occupancy
//   drop_err_out   : sticky, set when a vector start was refused
// ---------------------------------------------------------------------------
module hs_npu_result_collector #(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [31:0]        results_in [8],
    input  logic                      cfg_relu_in,
    input  logic        [4:0]         cfg_shift_in,
    output logic signed [15:0]        data_out [8],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fifo_count_out,
    output logic                      drop_err_out
);

    localparam int AW = $clog2(DEPTH);

    logic signed [31:0] aligned [8];
    logic        [6:0]  valid_pipe;
    logic        [3:0]  inflight;
    logic               post_valid;
    logic signed [15:0] post_data [8];
    logic signed [15:0] mem [DEPTH][8];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [AW+1:0]      occupancy;
    logic               push;
    logic               pop;
    logic               drop_err;

    // ReLU, then rounding shift in 33 bits so x + 2^(s-1) cannot overflow,
    // then saturate to the 16-bit signed range.
    function automatic logic signed [15:0] requant(
        input logic signed [31:0] x_in,
        input logic               relu,
        input logic        [4:0]  sh
    );
        logic signed [32:0] x;
        logic signed [32:0] rnd;
        x = {x_in[31], x_in};
        if (relu && x_in < 0) begin
            x = '0;
        end
        if (sh != 5'd0) begin
            rnd = 33'sd1 <<< (sh - 5'd1);
            x   = (x + rnd) >>> sh;
        end
        if (x > 33'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -33'sd32768) begin
            return 16'sh8000;
        end else begin
            return $signed(x[15:0]);
        end
    endfunction

    // Lane j needs 7-j cycles of delay to line up with lane 7. The delay
    // lines shift every cycle regardless of valid; validity travels in
    // valid_pipe alongside them.
    genvar j;
    generate
        for (j = 0; j < 7; j++) begin : g_lane
            localparam int LEN = 7 - j;
            logic signed [31:0] dly [LEN];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < LEN; k++) begin
                        dly[k] <= '0;
                    end
                end else begin
                    dly[0] <= results_in[j];
                    for (int k = 1; k < LEN; k++) begin
                        dly[k] <= dly[k-1];
                    end
                end
            end

            assign aligned[j] = dly[LEN-1];
        end
    endgenerate

    assign aligned[7] = results_in[7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[5:0], in_valid && in_ready};
        end
    end

    // Vectors accepted but not yet in the FIFO: everything in the valid
    // pipe plus the post stage. Reserving FIFO space for them up front is
    // what lets the FIFO write proceed without a full check.
    always_comb begin
        inflight = {3'b000, post_valid};
        for (int k = 0; k < 7; k++) begin
            inflight = inflight + {3'b000, valid_pipe[k]};
        end
    end

    assign occupancy = {1'b0, count} + (AW+2)'(inflight);
    assign in_ready  = occupancy < (AW+2)'(DEPTH);

    // Post stage: configuration is sampled in the cycle the vector aligns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_valid <= 1'b0;
            for (int l = 0; l < 8; l++) begin
                post_data[l] <= '0;
            end
        end else begin
            post_valid <= valid_pipe[6];
            for (int l = 0; l < 8; l++) begin
                post_data[l] <= requant(aligned[l], cfg_relu_in, cfg_shift_in);
            end
        end
    end

    assign push = post_valid;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            for (int l = 0; l < 8; l++) begin
                mem[wr_ptr][l] <= post_data[l];
            end
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            drop_err <= 1'b1;
        end
    end

    assign out_valid = (count != '0);

    always_comb begin
        for (int l = 0; l < 8; l++) begin
            data_out[l] = out_valid ? mem[rd_ptr][l] : 16'sd0;
        end
    end

    assign fifo_count_out = count;
    assign drop_err_out   = drop_err;

endmodule

// File: tb/tb_hs_npu_result_collector.sv
// ---------------------------------------------------------------------------
// tb_hs_npu_result_collector
//
// Drives hs_npu_result_collector cycle by cycle and compares every output
// against a transaction-level reference: per-cycle input history, a list of
// accepted vector start cycles, and a queue standing in for the FIFO.
// ---------------------------------------------------------------------------
module tb_hs_npu_result_collector;

    localparam int DEPTH = 16;
    localparam int MAXC  = 4096;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] results_in [8];
    logic               cfg_relu_in;
    logic        [4:0]  cfg_shift_in;
    logic signed [15:0] data_out [8];
    logic               out_valid;
    logic               out_ready;
    logic        [4:0]  fifo_count_out;
    logic               drop_err_out;

    always #5 clk = ~clk;

    hs_npu_result_collector #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .results_in     (results_in),
        .cfg_relu_in    (cfg_relu_in),
        .cfg_shift_in   (cfg_shift_in),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_count_out (fifo_count_out),
        .drop_err_out   (drop_err_out)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic signed [31:0] hist_res   [MAXC][8];
    bit                 hist_relu  [MAXC];
    logic        [4:0]  hist_shift [MAXC];
    bit                 acc_flag   [MAXC];
    logic [127:0]       model_q [$];
    bit                 model_drop = 1'b0;
    logic signed [31:0] stim_res [8];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One lane: ReLU, rounding shift, saturation in plain integer arithmetic.
    function automatic logic [15:0] refLane(input longint v, input bit relu, input int s);
        longint x;
        x = v;
        if (relu && x < 0) x = 0;
        if (s > 0) x = (x + (longint'(1) << (s - 1))) >>> s;
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        return x[15:0];
    endfunction

    // Vector started at cycle t: lane j came in at t+j, config taken at t+7.
    function automatic logic [127:0] refVector(input int t);
        logic [127:0] v;
        for (int j = 0; j < 8; j++) begin
            v[16*j +: 16] = refLane(longint'(hist_res[t+j][j]), hist_relu[t+7], int'(hist_shift[t+7]));
        end
        return v;
    endfunction

    function automatic logic [127:0] dutVec();
        logic [127:0] v;
        for (int j = 0; j < 8; j++) begin
            v[16*j +: 16] = data_out[j];
        end
        return v;
    endfunction

    task automatic randRes();
        for (int j = 0; j < 8; j++) begin
            case ($urandom_range(0, 3))
                0: stim_res[j] = $urandom;
                1: stim_res[j] = $signed($urandom_range(0, 200000)) - 100000;
                2: stim_res[j] = $urandom_range(0, 1) ? 32'sh7FFFFFFF : 32'sh80000000;
                default: stim_res[j] = $signed($urandom_range(0, 80000)) - 40000;
            endcase
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model across the coming edge, then wait for that edge.
    task automatic applyStimulus(input bit rstn, input bit vin, input bit ordy,
                                 input bit relu, input logic [4:0] sh, input bit do_check);
        int           infl;
        bit           exp_ready;
        bit           exp_valid;
        logic [127:0] exp_data;

        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end

        rst_n        = rstn;
        in_valid     = vin;
        out_ready    = ordy;
        cfg_relu_in  = relu;
        cfg_shift_in = sh;
        for (int j = 0; j < 8; j++) begin
            results_in[j]  = stim_res[j];
            hist_res[cyc][j] = stim_res[j];
        end
        hist_relu[cyc]  = relu;
        hist_shift[cyc] = sh;

        infl = 0;
        for (int k = cyc - 8; k < cyc; k++) begin
            if (k >= 0 && acc_flag[k]) infl++;
        end
        exp_ready = (model_q.size() + infl) < DEPTH;
        exp_valid = model_q.size() > 0;
        exp_data  = exp_valid ? model_q[0] : '0;

        #3;
        if (do_check) begin
            checkOutput("in_ready",   128'(in_ready),       128'(exp_ready));
            checkOutput("out_valid",  128'(out_valid),      128'(exp_valid));
            checkOutput("fifo_count", 128'(fifo_count_out), 128'(model_q.size()));
            checkOutput("drop_err",   128'(drop_err_out),   128'(model_drop));
            checkOutput("data_out",   dutVec(),             exp_data);
        end

        acc_flag[cyc] = 1'b0;
        if (!rstn) begin
            model_q.delete();
            for (int k = cyc - 8; k < cyc; k++) begin
                if (k >= 0) acc_flag[k] = 1'b0;
            end
            model_drop = 1'b0;
        end else begin
            if (exp_valid && ordy) void'(model_q.pop_front());
            if (cyc >= 8 && acc_flag[cyc-8]) model_q.push_back(refVector(cyc - 8));
            if (vin && exp_ready) acc_flag[cyc] = 1'b1;
            if (vin && !exp_ready) model_drop = 1'b1;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single vector with every lane equal to val, then a fixed-value check of
    // one lane at the FIFO head and a pop.
    task automatic runCorner(input string tag, input logic signed [31:0] val, input bit relu,
                             input logic [4:0] sh, input logic signed [15:0] expv);
        for (int c = 0; c < 9; c++) begin
            for (int j = 0; j < 8; j++) stim_res[j] = val;
            applyStimulus(1'b1, c == 0, 1'b0, relu, sh, 1'b1);
        end
        checkOutput(tag, {112'd0, data_out[3]}, {112'd0, expv});
        applyStimulus(1'b1, 1'b0, 1'b1, relu, sh, 1'b1);
    endtask

    initial begin
        bit         r_relu;
        logic [4:0] r_shift;
        int         p_valid;
        int         p_ready;

        for (int j = 0; j < 8; j++) stim_res[j] = '0;
        for (int k = 0; k < MAXC; k++) acc_flag[k] = 1'b0;
        @(posedge clk);
        #1;

        // Initial reset, outputs unknown until it lands.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);

        // Single vector: lane j = 1000+j delivered in cycle j, shift 2.
        for (int c = 0; c < 9; c++) begin
            randRes();
            if (c < 8) stim_res[c] = 1000 + c;
            applyStimulus(1'b1, c == 0, 1'b1, 1'b0, 5'd2, 1'b1);
        end
        checkOutput("single_valid", 128'(out_valid), 128'(1));
        checkOutput("single_lane0", {112'd0, data_out[0]}, 128'(250));
        checkOutput("single_lane7", {112'd0, data_out[7]}, 128'(252));
        for (int c = 0; c < 4; c++) begin
            randRes();
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
        end

        // Arithmetic corners.
        runCorner("corner_relu",    -32'sd5,       1'b1, 5'd0, 16'sd0);
        runCorner("corner_round",   -32'sd6,       1'b0, 5'd2, -16'sd1);
        runCorner("corner_sat_pos", 32'sh7FFFFFFF, 1'b0, 5'd0, 16'sh7FFF);
        runCorner("corner_sat_neg", 32'sh80000000, 1'b0, 5'd0, 16'sh8000);

        // Backpressure: continuous starts with the consumer stalled.
        for (int c = 0; c < DEPTH + 12; c++) begin
            randRes();
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'($urandom_range(0, 10)), 1'b1);
        end
        checkOutput("bp_count",    128'(fifo_count_out), 128'(DEPTH));
        checkOutput("bp_in_ready", 128'(in_ready),       128'(0));
        checkOutput("bp_drop",     128'(drop_err_out),   128'(1));
        for (int c = 0; c < DEPTH + 4; c++) begin
            randRes();
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
        end

        // Refill, then stream with pop and push together near full.
        for (int c = 0; c < DEPTH + 10; c++) begin
            randRes();
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
        end
        for (int c = 0; c < 40; c++) begin
            randRes();
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1);
        end

        // Reset mid-stream: two vectors in the FIFO, three in flight.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            randRes();
            applyStimulus(1'b1, (c < 2) || (c >= 7), 1'b0, 1'b0, 5'd1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
        checkOutput("rst_valid", 128'(out_valid),      128'(0));
        checkOutput("rst_count", 128'(fifo_count_out), 128'(0));
        for (int c = 0; c < 10; c++) begin
            randRes();
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
        end

        // Randomized traffic with shifting handshake rates and config.
        r_relu  = 1'b0;
        r_shift = 5'd0;
        p_valid = 60;
        p_ready = 50;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                p_valid = $urandom_range(10, 100);
                p_ready = $urandom_range(5, 100);
            end
            if ($urandom_range(0, 9) == 0) begin
                r_relu  = 1'($urandom_range(0, 1));
                r_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 12));
            end
            randRes();
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 99) < p_valid),
                          ($urandom_range(0, 99) < p_ready),
                          r_relu, r_shift, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
